// File: rtl/inst_mem_loader.sv
// Streams a program into instruction memory, then holds the core in reset for
// REL_CYC cycles before releasing it to run.
module inst_mem_loader #(
    parameter int DEPTH   = 100,
    parameter int REL_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [6:0]  word_count,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RELEASE = 2'd2,
        RUN     = 2'd3
    } state_t;

    localparam logic [7:0] DEPTH8   = 8'(DEPTH);
    localparam logic [7:0] REL_INIT = 8'(REL_CYC - 1);

    state_t      state;
    state_t      next_state;
    logic        rst_ok;
    logic [6:0]  index;
    logic [6:0]  last_idx;
    logic [7:0]  rel_cnt;
    logic        len_ok;
    logic        take_start;
    logic        beat;
    logic        last_beat;

    // rst_ok only rises on the first clock edge after reset is released,
    // so a start coinciding with that edge is not acted upon
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_ok <= 1'b0;
        else        rst_ok <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        len_ok     = (word_count != 7'd0) && ({1'b0, word_count} <= DEPTH8);
        take_start = rst_ok && start && ((state == IDLE) || (state == RUN));
        beat       = (state == LOAD) && s_valid;
        last_beat  = beat && (index == last_idx);
        case (state)
            IDLE, RUN: if (take_start && len_ok) next_state = LOAD;
            LOAD:      if (last_beat) next_state = RELEASE;
            RELEASE:   if (rel_cnt == 8'd0) next_state = RUN;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            index     <= 7'd0;
            last_idx  <= 7'd0;
            rel_cnt   <= 8'd0;
            err       <= 1'b0;
        end else begin
            mem_we <= beat;
            // index saturates on the last word so it never points past the program
            if (beat) begin
                mem_addr  <= {23'd0, index, 2'b00};
                mem_wdata <= s_data;
                if (!last_beat) index <= index + 7'd1;
            end
            if (take_start && len_ok) begin
                last_idx <= word_count - 7'd1;
                index    <= 7'd0;
                err      <= 1'b0;
            end else if (take_start) begin
                err <= 1'b1;
            end
            if (last_beat)
                rel_cnt <= REL_INIT;
            else if ((state == RELEASE) && (rel_cnt != 8'd0))
                rel_cnt <= rel_cnt - 8'd1;
        end
    end

    assign s_ready   = (state == LOAD);
    assign busy      = (state == LOAD) || (state == RELEASE);
    assign done      = (state == RUN);
    assign cpu_rst_n = (state == RUN);

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed self-checking bench for inst_mem_loader: load, stall, errors,
// full-depth load, reset abort and restart from RUN.
module tb_inst_mem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [6:0]  word_count;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int checks_total = 0;
    int checks_passed = 0;

    logic [31:0] words [0:127];
    logic [31:0] log_addr [$];
    logic [31:0] log_data [$];

    inst_mem_loader #(.DEPTH(100), .REL_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected)
            checks_passed++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] wc);
        start      = 1'b1;
        word_count = wc;
        tick();
        start = 1'b0;
    endtask

    // toggle=1 offers a word only on every other cycle
    task automatic sendWords(input int n, input bit toggle);
        int k = 0;
        int cyc = 0;
        logic rdy;
        while (k < n && cyc < 1000) begin
            if (toggle && (cyc % 2 == 1)) begin
                s_valid = 1'b0;
            end else begin
                s_valid = 1'b1;
                s_data  = words[k];
            end
            rdy = s_ready;
            tick();
            if (s_valid && rdy) k++;
            cyc++;
        end
        s_valid = 1'b0;
        if (k != n) checkOutput("beats_accepted", k, n);
    endtask

    task automatic waitRun();
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            tick();
        end
        checkOutput("run_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic clearLog();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        int rel;
        rst_n = 1'b0; start = 1'b0; word_count = 7'd0; s_valid = 1'b0; s_data = 32'd0;
        words[0] = 32'h20080005;
        words[1] = 32'h2009000C;
        words[2] = 32'h01095020;
        for (int i = 3; i < 128; i++) words[i] = 32'hA000_0000 | i;

        #3;
        checkOutput("rst_s_ready", {31'd0, s_ready}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        checkOutput("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        #19 rst_n = 1'b1;
        tick();
        tick();

        // basic three-word load
        clearLog();
        applyStimulus(7'd3);
        checkOutput("t1_busy", {31'd0, busy}, 32'd1);
        sendWords(3, 1'b0);
        checkOutput("t1_ready_after_last", {31'd0, s_ready}, 32'd0);
        rel = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            if (busy && !s_ready) rel++;
            tick();
        end
        checkOutput("t1_release_cycles", rel, 32'd2);
        checkOutput("t1_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
        checkOutput("t1_done", {31'd0, done}, 32'd1);
        checkOutput("t1_writes", log_addr.size(), 32'd3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            checkOutput("t1_addr", log_addr[i], 32'(i * 4));
            checkOutput("t1_data", log_data[i], words[i]);
        end

        // restart from RUN with two words
        clearLog();
        applyStimulus(7'd2);
        checkOutput("t6_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        checkOutput("t6_busy", {31'd0, busy}, 32'd1);
        sendWords(2, 1'b0);
        waitRun();
        checkOutput("t6_writes", log_addr.size(), 32'd2);
        if (log_addr.size() >= 2) begin
            checkOutput("t6_addr0", log_addr[0], 32'h0);
            checkOutput("t6_addr1", log_addr[1], 32'h4);
        end

        // four words with a stall between each
        clearLog();
        applyStimulus(7'd4);
        sendWords(4, 1'b1);
        waitRun();
        checkOutput("t2_writes", log_addr.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checkOutput("t2_addr", log_addr[i], 32'(i * 4));
            checkOutput("t2_data", log_data[i], words[i]);
        end

        // full-depth load
        clearLog();
        applyStimulus(7'd100);
        sendWords(100, 1'b0);
        checkOutput("t4_ready_after_100", {31'd0, s_ready}, 32'd0);
        waitRun();
        checkOutput("t4_writes", log_addr.size(), 32'd100);
        if (log_addr.size() == 100) begin
            checkOutput("t4_last_addr", log_addr[99], 32'h18C);
            checkOutput("t4_last_data", log_data[99], words[99]);
        end

        // reset two beats into a five-word load
        clearLog();
        applyStimulus(7'd5);
        sendWords(2, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t5_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("t5_mem_addr", mem_addr, 32'd0);
        checkOutput("t5_mem_wdata", mem_wdata, 32'd0);
        checkOutput("t5_flags", {28'd0, s_ready, busy, done, err}, 32'd0);
        checkOutput("t5_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd0);
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        tick();
        #2;
        rst_n      = 1'b1;
        start      = 1'b1;
        word_count = 7'd3;
        tick();
        start = 1'b0;
        checkOutput("t5_start_after_release_ignored", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        s_valid = 1'b0;
        checkOutput("t5_writes", log_addr.size(), 32'd2);

        // bad word counts from IDLE, then a good start clears err
        applyStimulus(7'd0);
        checkOutput("t3_err_zero", {31'd0, err}, 32'd1);
        checkOutput("t3_idle_zero", {30'd0, busy, cpu_rst_n}, 32'd0);
        applyStimulus(7'd101);
        checkOutput("t3_err_101", {31'd0, err}, 32'd1);
        checkOutput("t3_idle_101", {29'd0, busy, s_ready, cpu_rst_n}, 32'd0);
        applyStimulus(7'd3);
        checkOutput("t3_err_cleared", {31'd0, err}, 32'd0);
        checkOutput("t3_busy", {31'd0, busy}, 32'd1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
INST_MEM_LOADER -- requirements
Module: inst_mem_loader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 100, meaning the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter REL_CYC, default 2, meaning the number of cycles between load completion and processor reset release.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-005 Port start, input, 1 bit, SHALL be the single-cycle request to begin a program load.
REQ-006 Port word_count, input, 7 bits, SHALL be the number of words to load; sampled when start is accepted.
REQ-007 Port s_valid, input, 1 bit, SHALL indicate that s_data holds a valid instruction word.
REQ-008 Port s_data, input, 32 bits, SHALL be the instruction word stream.
REQ-009 Port s_ready, output, 1 bit, SHALL indicate the loader accepts s_data this cycle.
REQ-010 Port mem_we, output, 1 bit, SHALL be the instruction memory write enable.
REQ-011 Port mem_addr, output, 32 bits, SHALL be the byte address of the write, always word-aligned (bits [1:0] = 0).
REQ-012 Port mem_wdata, output, 32 bits, SHALL be the instruction memory write data.
REQ-013 Port cpu_rst_n, output, 1 bit, SHALL be the active-low reset driven to the processor core.
REQ-014 Ports busy, done, and err, outputs, 1 bit each, SHALL mean load in progress, program running, and sticky bad-request flag, respectively.

Function
REQ-015 The FSM SHALL have the states IDLE, LOAD, RELEASE, and RUN.
REQ-016 In IDLE, when start=1 and 1 <= word_count <= DEPTH, the FSM SHALL latch word_count, clear the word index to 0, clear err, and enter LOAD.
REQ-017 In IDLE or RUN, when start=1 and word_count=0 or word_count>DEPTH, the block SHALL set err=1 and leave the state unchanged.
REQ-018 s_ready SHALL be 1 exactly while in LOAD, decoded from the state register only, with no combinational path from s_valid.
REQ-019 A beat SHALL be accepted on a rising edge where s_valid=1 and s_ready=1; s_valid=0 cycles SHALL stall without side effects.
REQ-020 The cycle after an accepted beat, the block SHALL drive mem_we=1 for one cycle, with mem_addr = index*4 and mem_wdata = the accepted s_data.
REQ-021 The word index SHALL increment by 1 per accepted beat and SHALL never exceed DEPTH-1.
REQ-022 On acceptance of beat number word_count (the last beat), the FSM SHALL enter RELEASE on that same edge, so s_ready=0 on the following cycle.
REQ-023 RELEASE SHALL last exactly REL_CYC cycles, counted by a down-counter, and then transition to RUN.
REQ-024 cpu_rst_n SHALL be 0 in IDLE, LOAD, and RELEASE, and 1 only in RUN.
REQ-025 busy SHALL be 1 in LOAD and RELEASE; done SHALL be 1 only in RUN.
REQ-026 A start pulse in LOAD or RELEASE SHALL be ignored.
REQ-027 A valid start in RUN SHALL return the FSM to LOAD (index=0), dropping cpu_rst_n to 0 on the next cycle.
REQ-028 Outside the cycle following an accepted beat, mem_we SHALL be 0, and mem_addr/mem_wdata SHALL hold their last values.
REQ-029 err SHALL remain set until the next valid start or reset.

Reset
REQ-030 On assertion of rst_n=0, regardless of clk, the block SHALL enter IDLE and drive s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, and clear the index and counters.
REQ-031 A reset asserted mid-LOAD SHALL abort the load immediately; no further mem_we pulse SHALL follow.
REQ-032 Release of reset SHALL be synchronised internally so the FSM leaves IDLE only on a start sampled after rst_n has been high for at least one rising edge.

Verification
REQ-033 A bench SHALL apply start with word_count=3 and continuous s_valid carrying 0x20080005, 0x2009000C, and 0x01095020, and SHALL check three mem_we pulses at addresses 0x0, 0x4, and 0x8 with matching data, then 2 RELEASE cycles, then cpu_rst_n=1 and done=1.
REQ-034 A bench SHALL apply word_count=4 with s_valid toggling every other cycle and SHALL check exactly 4 writes at addresses 0x0 through 0xC, with no write during stall cycles.
REQ-035 A bench SHALL apply start with word_count=0, then with word_count=101, and SHALL check that err=1, the state remains IDLE, and cpu_rst_n=0; a subsequent valid start SHALL clear err.
REQ-036 A bench SHALL apply word_count=100 and SHALL check that the last write is at address 0x18C and that s_ready=0 on the cycle after the 100th beat.
REQ-037 A bench SHALL assert rst_n=0 after 2 of 5 beats and SHALL check that all outputs return to their reset values asynchronously and that no further mem_we pulse occurs.
REQ-038 A bench SHALL apply a valid start with word_count=2 while in RUN and SHALL check that cpu_rst_n falls, busy=1, and the writes restart at address 0x0.
